// File: rtl/bit_serial_operand_shifter.sv
// bit_serial_operand_shifter
//   Upstream feeder for the bit-serial adder. Accepts a pair of W-bit
//   operands over valid/ready, then shifts both out LSB-first, one bit
//   per clock, with first/last framing strobes. Back-to-back words run
//   with no idle cycle between them.
//
//   Build option: define BIT_SERIAL_SHIFTER_GUARD_EN to append one guard
//   bit after the MSB (word length W+1). The guard bit is the operand MSB
//   when SIGNED=1, else 0. Without the macro the word length is W.
//
// Ports
//   clk       in   clock, rising edge
//   reset     in   asynchronous, active-high reset
//   in_valid  in   operand pair valid
//   in_ready  out  operand pair can be accepted this cycle
//   in_a/in_b in   W-bit parallel operands
//   a/b       out  serial operand bits, LSB first
//   s_valid   out  a/b carry a valid bit
//   s_first   out  bit 0 of a word (downstream clears carry)
//   s_last    out  final bit of a word
//   busy      out  a word is being shifted
module bit_serial_operand_shifter #(
    parameter int W      = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         a,
    output logic         b,
    output logic         s_valid,
    output logic         s_first,
    output logic         s_last,
    output logic         busy
);

`ifdef BIT_SERIAL_SHIFTER_GUARD_EN
    localparam int N = W + 1;
`else
    localparam int N = W;
`endif
    localparam int            CW   = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;       // index of the bit currently on a/b
    logic [N-1:0]  sh_a_q;      // bits still to send; bit 0 goes out next
    logic [N-1:0]  sh_b_q;
    logic          a_q, b_q, first_q, last_q;

    logic          ext_a, ext_b;
    logic [N-1:0]  ld_a, ld_b;
    logic [CW-1:0] cnt_d;
    logic          hs;

    // Extension bit seeds the top of the shift register and is replicated
    // as it shifts. Without the guard bit it never reaches the output.
    assign ext_a = SIGNED ? in_a[W-1] : 1'b0;
    assign ext_b = SIGNED ? in_b[W-1] : 1'b0;

`ifdef BIT_SERIAL_SHIFTER_GUARD_EN
    assign ld_a = {ext_a, in_a};
    assign ld_b = {ext_b, in_b};
`else
    assign ld_a = in_a;
    assign ld_b = in_b;
`endif

    // Ready in IDLE and on the last-bit cycle, which is what gives the
    // zero-gap hand-over between consecutive words.
    assign in_ready = ~reset & ((state_q == IDLE) | last_q);
    assign hs       = in_valid & in_ready;
    assign cnt_d    = cnt_q + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (hs) begin
            // Bit 0 goes straight to the output flops; the rest wait in
            // the shift register with the extension bit on top.
            state_q <= SHIFT;
            cnt_q   <= '0;
            a_q     <= ld_a[0];
            b_q     <= ld_b[0];
            sh_a_q  <= {ext_a, ld_a[N-1:1]};
            sh_b_q  <= {ext_b, ld_b[N-1:1]};
            first_q <= 1'b1;
            last_q  <= 1'b0;
        end else if (state_q == SHIFT && !last_q) begin
            cnt_q   <= cnt_d;
            a_q     <= sh_a_q[0];
            b_q     <= sh_b_q[0];
            sh_a_q  <= {sh_a_q[N-1], sh_a_q[N-1:1]};
            sh_b_q  <= {sh_b_q[N-1], sh_b_q[N-1:1]};
            first_q <= 1'b0;
            last_q  <= (cnt_d == LAST);
        end else begin
            // Word finished with no follow-on handshake, or idle.
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

    assign a       = a_q;
    assign b       = b_q;
    assign s_first = first_q;
    assign s_last  = last_q;
    assign busy    = (state_q == SHIFT);
    assign s_valid = (state_q == SHIFT);

endmodule

// File: tb/tb_bit_serial_operand_shifter.sv
// Directed bench for bit_serial_operand_shifter: table of single words,
// plus back-to-back, async reset and ignored-request sequences.
module tb_bit_serial_operand_shifter;

    localparam int W      = 8;
    localparam bit SIGNED = 1'b1;
`ifdef BIT_SERIAL_SHIFTER_GUARD_EN
    localparam int N = W + 1;
`else
    localparam int N = W;
`endif
    localparam int NMAX = W + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         a, b, s_valid, s_first, s_last, busy;

    int checks = 0;
    int failures = 0;

    bit_serial_operand_shifter #(.W(W), .SIGNED(SIGNED)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .a(a), .b(b), .s_valid(s_valid),
        .s_first(s_first), .s_last(s_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] ia;
        logic [W-1:0] ib;
        logic [W-1:0] ea;   // expected stream, bit i = serial bit i
        logic [W-1:0] eb;
        int           poke; // bit index where a stray request is pulsed, -1 none
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Expected N-bit stream for one operand, including the guard bit if built.
    function automatic logic [NMAX-1:0] wexp(input logic [W-1:0] x);
`ifdef BIT_SERIAL_SHIFTER_GUARD_EN
        return {(SIGNED ? x[W-1] : 1'b0), x};
`else
        return {1'b0, x};
`endif
    endfunction

    task automatic chk_idle(input string nm);
        chk({nm, ".idle_out"}, 64'({a, b, s_valid, s_first, s_last, busy}), 64'd0);
        chk({nm, ".idle_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic run_word(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic [NMAX-1:0] ea, input logic [NMAX-1:0] eb, input int poke);
        logic [NMAX-1:0] ga, gb, gv, gf, gl, gr;
        ga = '0; gb = '0; gv = '0; gf = '0; gl = '0; gr = '0;
        @(negedge clk);
        in_valid = 1'b1; in_a = ia; in_b = ib;
        chk({nm, ".ready0"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            ga[i] = a; gb[i] = b; gv[i] = s_valid; gf[i] = s_first; gl[i] = s_last; gr[i] = in_ready;
            if (i == poke) begin
                in_valid = 1'b1; in_a = 8'h12; in_b = 8'h34;
            end else begin
                in_valid = 1'b0;
            end
        end
        chk({nm, ".a"}, 64'(ga), 64'(ea));
        chk({nm, ".b"}, 64'(gb), 64'(eb));
        chk({nm, ".valid"}, 64'(gv), (64'd1 << N) - 64'd1);
        chk({nm, ".first"}, 64'(gf), 64'd1);
        chk({nm, ".last"}, 64'(gl), 64'd1 << (N - 1));
        chk({nm, ".ready"}, 64'(gr), 64'd1 << (N - 1));
        @(negedge clk);
        chk_idle(nm);
    endtask

    task automatic run_b2b(input logic [W-1:0] a1, input logic [W-1:0] b1,
                           input logic [W-1:0] a2, input logic [W-1:0] b2);
        logic [2*NMAX-1:0] ga, gb, gv, gf, gl, gr, ea, eb;
        ga = '0; gb = '0; gv = '0; gf = '0; gl = '0; gr = '0;
        ea = ((2*NMAX)'(wexp(a2)) << N) | (2*NMAX)'(wexp(a1));
        eb = ((2*NMAX)'(wexp(b2)) << N) | (2*NMAX)'(wexp(b1));
        @(negedge clk);
        in_valid = 1'b1; in_a = a1; in_b = b1;
        chk("b2b.ready0", 64'(in_ready), 64'd1);
        @(posedge clk);
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            ga[i] = a; gb[i] = b; gv[i] = s_valid; gf[i] = s_first; gl[i] = s_last; gr[i] = in_ready;
            if (i == 0) begin
                in_a = a2; in_b = b2;   // next pair presented immediately, held
            end
            if (i == N) in_valid = 1'b0;
        end
        chk("b2b.a", 64'(ga), 64'(ea));
        chk("b2b.b", 64'(gb), 64'(eb));
        chk("b2b.valid", 64'(gv), (64'd1 << (2 * N)) - 64'd1);
        chk("b2b.first", 64'(gf), 64'd1 | (64'd1 << N));
        chk("b2b.last", 64'(gl), (64'd1 << (N - 1)) | (64'd1 << (2 * N - 1)));
        chk("b2b.ready", 64'(gr), (64'd1 << (N - 1)) | (64'd1 << (2 * N - 1)));
        @(negedge clk);
        chk_idle("b2b");
    endtask

    initial begin
        int vcount;
        tbl[0] = '{ia: 8'hA5, ib: 8'h3C, ea: 8'hA5, eb: 8'h3C, poke: -1};
        tbl[1] = '{ia: 8'h80, ib: 8'h7F, ea: 8'h80, eb: 8'h7F, poke: -1};
        tbl[2] = '{ia: 8'hFF, ib: 8'h00, ea: 8'hFF, eb: 8'h00, poke: -1};
        tbl[3] = '{ia: 8'h00, ib: 8'hFF, ea: 8'h00, eb: 8'hFF, poke: -1};
        tbl[4] = '{ia: 8'h55, ib: 8'hAA, ea: 8'h55, eb: 8'hAA, poke: -1};
        tbl[5] = '{ia: 8'hC3, ib: 8'h5A, ea: 8'hC3, eb: 8'h5A, poke: 2};

        // Reset, release, then 20 idle cycles with no serial activity.
        #12;
        chk("rst.out", 64'({a, b, s_valid, s_first, s_last, busy}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst.ready", 64'(in_ready), 64'd1);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_valid || busy) vcount++;
        end
        chk("idle20.valid", 64'(vcount), 64'd0);

        for (int i = 0; i < 6; i++)
            run_word($sformatf("vec%0d", i), tbl[i].ia, tbl[i].ib,
                     wexp(tbl[i].ea), wexp(tbl[i].eb), tbl[i].poke);

        run_b2b(8'h01, 8'hFF, 8'h80, 8'h01);

        // Asynchronous reset three bits into an all-ones word.
        @(negedge clk);
        in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        chk("midrst.pre", 64'({a, b, s_valid, busy}), 64'hF);
        #2 reset = 1'b1;
        #1;
        chk("midrst.out", 64'({a, b, s_valid, s_first, s_last, busy}), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst.ready", 64'(in_ready), 64'd1);
        run_word("postrst", 8'h55, 8'h0F, wexp(8'h55), wexp(8'h0F), -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
